complex_result_pipe: RTL and testbench
======================================

// Module: complex_result_pipe
// PURPOSE
// - Receiving end of the complex ALU result interface (result + execution flags); paces
//   complex-ALU ops to the writeback stage.
// - Captures each issued op's result, flags and destination tag, then holds it for a
//   fixed LATENCY that models multiplier/divider depth.
// - Presents the op to writeback over a valid/ready handshake.
// - Bubble-collapsing stage pipe: an op advances whenever the stage ahead is empty or
//   moving. Backpressure propagates to the issue side.
// PARAMETERS
// - LATENCY    3                  number of register stages, input to writeback; >= 1
// - TAG_W      `SIZE_PHYSICAL_LOG destination physical-register tag width
// - DATA_W     `SIZE_DATA         result width
// - FLAGS_W    `EXECUTION_FLAGS   execution-flag width
// PORTS
// - clk            in   1          rising-edge clock
// - reset          in   1          synchronous, active-high
// - flush_i        in   1          squash every in-flight op (mispredict/exception recovery)
// - in_valid_i     in   1          op from the complex ALU is presented this cycle
// - in_ready_o     out  1          pipe accepts the op this cycle
// - in_tag_i       in   TAG_W      destination tag of the presented op
// - alu_result_i   in   DATA_W     result from the complex ALU
// - alu_flags_i    in   FLAGS_W    flags from the complex ALU
// - wb_valid_o     out  1          writeback payload valid
// - wb_ready_i     in   1          writeback consumes the payload this cycle
// - wb_tag_o       out  TAG_W      destination tag
// - wb_result_o    out  DATA_W     result
// - wb_flags_o     out  FLAGS_W    flags, passed through bit-exact
// - occupancy_o    out  $clog2(LATENCY+1)  count of valid stages
// BEHAVIOUR
// - Reset (sync, active-high): all stage valids = 0; wb_valid_o = 0; occupancy_o = 0;
//   wb_tag/result/flags_o = 0. in_ready_o = 1 in the first cycle after reset deasserts.
// - Stages S0..S(LATENCY-1); each has vld, tag, result, flags. S(LATENCY-1) drives wb_*_o
//   directly from registers (no comb path from the inputs).
// - Advance rules:
//     mv[L-1] = vld[L-1] & wb_ready_i
//     mv[k]   = vld[k] & (~vld[k+1] | mv[k+1])
//     in_ready_o = ~vld[0] | mv[0]
// - Accept: in_valid_i & in_ready_o loads S0 at the clock edge. S(k+1) loads from S(k) when mv[k].
// - A stage with mv=1 and no incoming op clears its vld.
// - Latency: an op accepted at edge t shows wb_valid_o=1 after edge t+LATENCY-1 when
//   unstalled. Pipe sustains 1 op/cycle.
// - Hold: while wb_valid_o & ~wb_ready_i, wb_tag/result/flags_o stay stable. Upstream
//   stages keep collapsing bubbles until the pipe is full.
// - Full: all vld=1 and wb_ready_i=0 -> in_ready_o=0. An input presented then is not
//   captured; the issuer holds it.
// - Full + wb_ready_i=1: everything shifts, in_ready_o=1, accept and retire in the same
//   cycle, occupancy unchanged.
// - flush_i: next cycle all vld=0 and occupancy 0. Flush beats a same-cycle accept: the op
//   is dropped although in_ready_o was 1.
//   - A same-cycle wb handshake still counts as consumed by writeback.
// - reset mid-operation: same as flush, and also zeroes the payload registers.
// - occupancy_o = popcount(vld), registered.
//   - next = cur + accept - retire; flush/reset forces 0.
// - Data payload regs load only on a move/accept (enable-gated); vld regs are the only
//   state that reset/flush must clear.
// - LATENCY=1: S0 is the output stage; in_ready_o = ~vld[0] | wb_ready_i.
// STRUCTURE
// - Shared header: TAG/DATA/FLAGS width macros (existing `SIZE_PHYSICAL_LOG, `SIZE_DATA,
//   `EXECUTION_FLAGS); no new package types.
// - One sub-module: result_pipe_stage, a single vld+payload register with load/clear.
//   Instantiated LATENCY times via generate.
// - Top level holds the mv[] chain, the occupancy counter and the flush/reset muxing.
// TESTING
// - Reset then idle: reset 2 cycles -> wb_valid_o=0, occupancy_o=0, in_ready_o=1.
// - Streaming, LATENCY=3, wb_ready_i=1: tags 1..8 on consecutive cycles.
//   -> tag1 at wb 2 cycles after accept; tags 1..8 on consecutive cycles in order;
//      results/flags bit-exact.
// - Backpressure: wb_ready_i=0 with 5 ops offered.
//   -> 3 accepted, in_ready_o=0, occupancy_o=3, wb_tag_o=1 held stable.
//   - Release wb_ready_i -> tags 1..5 drain in order with no loss or duplication.
// - Bubble collapse: accept tag 7, idle 2 cycles, accept tag 9, wb_ready_i=0.
//   -> occupancy_o=2; tags 7 then 9 adjacent at the output once ready.
// - Flush with simultaneous accept: pipe holding 2 ops + flush_i=1 + in_valid_i=1.
//   -> next cycle occupancy_o=0, wb_valid_o=0; that op never appears at wb.
// - Full shift: pipe full, wb_ready_i=1, in_valid_i=1 every cycle.
//   -> occupancy_o stays 3, 1 op/cycle out; with LATENCY=1 build, same check.

Source files
------------

// File: rtl/complex_result_pipe_pkg.sv
// Shared widths for the complex-ALU result path: destination tag, result data and execution flags.
package complex_result_pipe_pkg;
   localparam int SIZE_PHYSICAL_LOG = 6;
   localparam int SIZE_DATA         = 32;
   localparam int EXECUTION_FLAGS   = 5;
endpackage

// File: rtl/complex_result_pipe_stage.sv
// One pipe stage: a valid bit plus a tag/result/flags payload.
// Only the valid bit is cleared by flush. Reset clears the valid bit and the payload.
module result_pipe_stage
   import complex_result_pipe_pkg::*;
#(
   parameter int TAG_W   = SIZE_PHYSICAL_LOG,
   parameter int DATA_W  = SIZE_DATA,
   parameter int FLAGS_W = EXECUTION_FLAGS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               flush,
   input  logic               load,
   input  logic               drain,
   input  logic [TAG_W-1:0]   d_tag,
   input  logic [DATA_W-1:0]  d_result,
   input  logic [FLAGS_W-1:0] d_flags,
   output logic               vld,
   output logic [TAG_W-1:0]   q_tag,
   output logic [DATA_W-1:0]  q_result,
   output logic [FLAGS_W-1:0] q_flags
);

   always_ff @(posedge clk) begin
      if (reset || flush)
         vld <= 1'b0;
      else if (load)
         vld <= 1'b1;
      else if (drain)
         vld <= 1'b0;
   end

   // The payload registers are enable-gated. They are zeroed only by reset, not by flush.
   always_ff @(posedge clk) begin
      if (reset) begin
         q_tag    <= '0;
         q_result <= '0;
         q_flags  <= '0;
      end else if (load) begin
         q_tag    <= d_tag;
         q_result <= d_result;
         q_flags  <= d_flags;
      end
   end

endmodule

// File: rtl/complex_result_pipe.sv
// Fixed-latency, bubble-collapsing result pipe between the complex ALU and writeback.
// The writeback outputs come straight from the last stage's registers.
module complex_result_pipe
   import complex_result_pipe_pkg::*;
#(
   parameter int LATENCY = 3,
   parameter int TAG_W   = SIZE_PHYSICAL_LOG,
   parameter int DATA_W  = SIZE_DATA,
   parameter int FLAGS_W = EXECUTION_FLAGS
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           flush_i,
   input  logic                           in_valid_i,
   output logic                           in_ready_o,
   input  logic [TAG_W-1:0]               in_tag_i,
   input  logic [DATA_W-1:0]              alu_result_i,
   input  logic [FLAGS_W-1:0]             alu_flags_i,
   output logic                           wb_valid_o,
   input  logic                           wb_ready_i,
   output logic [TAG_W-1:0]               wb_tag_o,
   output logic [DATA_W-1:0]              wb_result_o,
   output logic [FLAGS_W-1:0]             wb_flags_o,
   output logic [$clog2(LATENCY+1)-1:0]   occupancy_o
);

   localparam int OCC_W = $clog2(LATENCY+1);

   logic [LATENCY-1:0]  vld;
   logic [LATENCY-1:0]  mv;
   logic [LATENCY-1:0]  load;
   logic [TAG_W-1:0]    st_tag    [LATENCY];
   logic [DATA_W-1:0]   st_result [LATENCY];
   logic [FLAGS_W-1:0]  st_flags  [LATENCY];
   logic [TAG_W-1:0]    src_tag    [LATENCY];
   logic [DATA_W-1:0]   src_result [LATENCY];
   logic [FLAGS_W-1:0]  src_flags  [LATENCY];
   logic                accept;
   logic                retire;
   logic [OCC_W-1:0]    occ_next;

   // Moves are resolved from the output end backwards, so each stage sees whether the stage ahead is leaving.
   always_comb begin
      mv = '0;
      mv[LATENCY-1] = vld[LATENCY-1] & wb_ready_i;
      for (int k = LATENCY-2; k >= 0; k--)
         mv[k] = vld[k] & (~vld[k+1] | mv[k+1]);
   end

   assign in_ready_o = ~vld[0] | mv[0];
   assign accept     = in_valid_i & in_ready_o;
   assign retire     = mv[LATENCY-1];

   for (genvar k = 0; k < LATENCY; k++) begin : g_stage
      if (k == 0) begin : g_head
         assign load[k]       = accept;
         assign src_tag[k]    = in_tag_i;
         assign src_result[k] = alu_result_i;
         assign src_flags[k]  = alu_flags_i;
      end else begin : g_body
         assign load[k]       = mv[k-1];
         assign src_tag[k]    = st_tag[k-1];
         assign src_result[k] = st_result[k-1];
         assign src_flags[k]  = st_flags[k-1];
      end

      result_pipe_stage #(
         .TAG_W   (TAG_W),
         .DATA_W  (DATA_W),
         .FLAGS_W (FLAGS_W)
      ) u_stage (
         .clk      (clk),
         .reset    (reset),
         .flush    (flush_i),
         .load     (load[k]),
         .drain    (mv[k]),
         .d_tag    (src_tag[k]),
         .d_result (src_result[k]),
         .d_flags  (src_flags[k]),
         .vld      (vld[k]),
         .q_tag    (st_tag[k]),
         .q_result (st_result[k]),
         .q_flags  (st_flags[k])
      );
   end

   assign wb_valid_o  = vld[LATENCY-1];
   assign wb_tag_o    = st_tag[LATENCY-1];
   assign wb_result_o = st_result[LATENCY-1];
   assign wb_flags_o  = st_flags[LATENCY-1];

   always_comb begin
      occ_next = occupancy_o;
      if (reset || flush_i)
         occ_next = '0;
      else
         occ_next = occupancy_o + OCC_W'(accept) - OCC_W'(retire);
   end

   always_ff @(posedge clk) begin
      occupancy_o <= occ_next;
   end

endmodule

// File: tb/tb_complex_result_pipe.sv
// Scoreboard bench for complex_result_pipe. Instance u_dut uses LATENCY=3 and u_dut1 uses LATENCY=1.
// The two instances share their inputs.
module tb_complex_result_pipe;
   import complex_result_pipe_pkg::*;

   localparam int TAG_W   = SIZE_PHYSICAL_LOG;
   localparam int DATA_W  = SIZE_DATA;
   localparam int FLAGS_W = EXECUTION_FLAGS;

   typedef struct packed {
      logic [TAG_W-1:0]   tag;
      logic [DATA_W-1:0]  res;
      logic [FLAGS_W-1:0] flg;
   } op_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic flush_i = 1'b0;
   logic in_valid_i = 1'b0;
   logic [TAG_W-1:0]   in_tag_i = '0;
   logic [DATA_W-1:0]  alu_result_i = '0;
   logic [FLAGS_W-1:0] alu_flags_i = '0;
   logic wb_ready_i = 1'b0;

   logic in_ready_o, wb_valid_o;
   logic [TAG_W-1:0]   wb_tag_o;
   logic [DATA_W-1:0]  wb_result_o;
   logic [FLAGS_W-1:0] wb_flags_o;
   logic [1:0]         occupancy_o;

   logic in_ready1, wb_valid1;
   logic [TAG_W-1:0]   wb_tag1;
   logic [DATA_W-1:0]  wb_result1;
   logic [FLAGS_W-1:0] wb_flags1;
   logic [0:0]         occupancy1;

   int total = 0;
   int bad = 0;
   int ret3 = 0;
   int ret1 = 0;
   int next_tag;
   op_t q3[$];
   op_t q1[$];

   complex_result_pipe #(.LATENCY(3)) u_dut (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_tag_i(in_tag_i),
      .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
      .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag_o),
      .wb_result_o(wb_result_o), .wb_flags_o(wb_flags_o), .occupancy_o(occupancy_o)
   );

   complex_result_pipe #(.LATENCY(1)) u_dut1 (
      .clk(clk), .reset(reset), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready1), .in_tag_i(in_tag_i),
      .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i),
      .wb_valid_o(wb_valid1), .wb_ready_i(wb_ready_i), .wb_tag_o(wb_tag1),
      .wb_result_o(wb_result1), .wb_flags_o(wb_flags1), .occupancy_o(occupancy1)
   );

   always #5 clk = ~clk;

   function automatic op_t make_op(input int t);
      op_t o;
      o.tag = TAG_W'(t);
      o.res = (32'h9E37_79B9 * 32'(t)) ^ 32'h0000_5A5A;
      o.flg = FLAGS_W'(t) ^ 5'h15;
      return o;
   endfunction

   task automatic drive(input logic v, input int t);
      op_t o;
      o = make_op(t);
      in_valid_i   = v;
      in_tag_i     = v ? o.tag : '0;
      alu_result_i = v ? o.res : '0;
      alu_flags_i  = v ? o.flg : '0;
   endtask

   // Scoreboard. Handshakes are sampled mid-cycle, so each one describes what the next rising edge does.
   always @(negedge clk) begin
      op_t e;
      if (reset) begin
         q3.delete();
         q1.delete();
      end else begin
         if (wb_valid_o && wb_ready_i) begin
            total++;
            ret3++;
            if (q3.size() == 0) begin
               bad++;
               $display("FAIL wb3_unexpected got tag=%0d with nothing expected", wb_tag_o);
            end else begin
               e = q3.pop_front();
               if ({wb_tag_o, wb_result_o, wb_flags_o} !== e) begin
                  bad++;
                  $display("FAIL wb3_payload got tag=%0d res=%h flg=%h want tag=%0d res=%h flg=%h",
                           wb_tag_o, wb_result_o, wb_flags_o, e.tag, e.res, e.flg);
               end
            end
         end
         if (wb_valid1 && wb_ready_i) begin
            total++;
            ret1++;
            if (q1.size() == 0) begin
               bad++;
               $display("FAIL wb1_unexpected got tag=%0d with nothing expected", wb_tag1);
            end else begin
               e = q1.pop_front();
               if ({wb_tag1, wb_result1, wb_flags1} !== e) begin
                  bad++;
                  $display("FAIL wb1_payload got tag=%0d res=%h flg=%h want tag=%0d res=%h flg=%h",
                           wb_tag1, wb_result1, wb_flags1, e.tag, e.res, e.flg);
               end
            end
         end
         if (flush_i) begin
            q3.delete();
            q1.delete();
         end else begin
            if (in_valid_i && in_ready_o) q3.push_back(make_op(int'(in_tag_i)));
            if (in_valid_i && in_ready1)  q1.push_back(make_op(int'(in_tag_i)));
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b1; flush_i = 1'b0; wb_ready_i = 1'b0;
      drive(1'b0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic drain_idle(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk); #1;
         drive(1'b0, 0);
         wb_ready_i = 1'b1;
      end
      @(negedge clk);
      total++;
      if (q3.size() != 0 || q1.size() != 0 || occupancy_o !== 2'd0 || occupancy1 !== 1'b0) begin
         bad++;
         $display("FAIL drain_empty got q3=%0d q1=%0d occ3=%0d occ1=%0d want all 0",
                  q3.size(), q1.size(), occupancy_o, occupancy1);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      total++;
      if (wb_valid_o !== 1'b0 || occupancy_o !== 2'd0 || in_ready_o !== 1'b1) begin
         bad++;
         $display("FAIL reset_ctrl got wbv=%b occ=%0d rdy=%b want 0 0 1", wb_valid_o, occupancy_o, in_ready_o);
      end
      total++;
      if (wb_tag_o !== '0 || wb_result_o !== '0 || wb_flags_o !== '0) begin
         bad++;
         $display("FAIL reset_payload got tag=%0d res=%h flg=%h want zeros", wb_tag_o, wb_result_o, wb_flags_o);
      end
      total++;
      if (wb_valid1 !== 1'b0 || occupancy1 !== 1'b0 || in_ready1 !== 1'b1) begin
         bad++;
         $display("FAIL reset_l1 got wbv=%b occ=%0d rdy=%b want 0 0 1", wb_valid1, occupancy1, in_ready1);
      end
   endtask

   task automatic test_streaming();
      do_reset();
      for (int i = 0; i <= 10; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b1;
         if (i < 8) drive(1'b1, i + 1); else drive(1'b0, 0);
         @(negedge clk);
         total++;
         if (wb_valid_o !== (i >= 3)) begin
            bad++;
            $display("FAIL stream_valid cycle=%0d got %b want %b", i, wb_valid_o, (i >= 3));
         end
         if (i >= 3) begin
            total++;
            if (wb_tag_o !== TAG_W'(i - 2)) begin
               bad++;
               $display("FAIL stream_tag cycle=%0d got %0d want %0d", i, wb_tag_o, i - 2);
            end
         end
      end
      drain_idle(4);
   endtask

   task automatic test_backpressure();
      int r0;
      do_reset();
      r0 = ret3;
      next_tag = 1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b0;
         drive(1'b1, next_tag);
         @(negedge clk);
         if (in_valid_i && in_ready_o) next_tag++;
      end
      total++;
      if (next_tag !== 4 || in_ready_o !== 1'b0 || occupancy_o !== 2'd3) begin
         bad++;
         $display("FAIL bp_full got accepted=%0d rdy=%b occ=%0d want 3 0 3", next_tag - 1, in_ready_o, occupancy_o);
      end
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         @(negedge clk);
         total++;
         if (wb_valid_o !== 1'b1 || wb_tag_o !== TAG_W'(1)) begin
            bad++;
            $display("FAIL bp_hold got wbv=%b tag=%0d want 1 1", wb_valid_o, wb_tag_o);
         end
      end
      for (int i = 0; i < 12 && next_tag <= 5; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b1;
         drive(1'b1, next_tag);
         @(negedge clk);
         if (in_valid_i && in_ready_o) next_tag++;
      end
      total++;
      if (next_tag !== 6) begin
         bad++;
         $display("FAIL bp_issue_timeout got accepted=%0d want 5", next_tag - 1);
      end
      drain_idle(5);
      total++;
      if (ret3 - r0 !== 5) begin
         bad++;
         $display("FAIL bp_retired got %0d want 5", ret3 - r0);
      end
   endtask

   task automatic test_bubble();
      int seq[6] = '{7, 0, 0, 9, 0, 0};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b0;
         drive(seq[i] != 0, seq[i]);
      end
      @(posedge clk); #1;
      drive(1'b0, 0);
      @(negedge clk);
      total++;
      if (occupancy_o !== 2'd2 || wb_tag_o !== TAG_W'(7)) begin
         bad++;
         $display("FAIL bubble_occ got occ=%0d tag=%0d want 2 7", occupancy_o, wb_tag_o);
      end
      @(posedge clk); #1;
      wb_ready_i = 1'b1;
      @(negedge clk);
      total++;
      if (wb_valid_o !== 1'b1 || wb_tag_o !== TAG_W'(7)) begin
         bad++;
         $display("FAIL bubble_first got wbv=%b tag=%0d want 1 7", wb_valid_o, wb_tag_o);
      end
      @(posedge clk); #1;
      @(negedge clk);
      total++;
      if (wb_valid_o !== 1'b1 || wb_tag_o !== TAG_W'(9)) begin
         bad++;
         $display("FAIL bubble_second got wbv=%b tag=%0d want 1 9", wb_valid_o, wb_tag_o);
      end
      drain_idle(3);
   endtask

   task automatic test_flush();
      int r0;
      do_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b0;
         if (i < 2) drive(1'b1, i + 1); else drive(1'b0, 0);
      end
      @(posedge clk); #1;
      flush_i = 1'b1;
      drive(1'b1, 20);
      @(negedge clk);
      total++;
      if (in_ready_o !== 1'b1 || occupancy_o !== 2'd2) begin
         bad++;
         $display("FAIL flush_pre got rdy=%b occ=%0d want 1 2", in_ready_o, occupancy_o);
      end
      r0 = ret3;
      @(posedge clk); #1;
      flush_i = 1'b0;
      drive(1'b0, 0);
      @(negedge clk);
      total++;
      if (occupancy_o !== 2'd0 || wb_valid_o !== 1'b0 || occupancy1 !== 1'b0 || wb_valid1 !== 1'b0) begin
         bad++;
         $display("FAIL flush_post got occ=%0d wbv=%b occ1=%0d wbv1=%b want 0 0 0 0",
                  occupancy_o, wb_valid_o, occupancy1, wb_valid1);
      end
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b1;
         @(negedge clk);
         total++;
         if (wb_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_leak cycle=%0d got wbv=%b tag=%0d want 0", i, wb_valid_o, wb_tag_o);
         end
      end
      total++;
      if (ret3 !== r0) begin
         bad++;
         $display("FAIL flush_retired got %0d want 0", ret3 - r0);
      end
   endtask

   task automatic test_full_shift();
      do_reset();
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         wb_ready_i = 1'b1;
         drive(1'b1, i + 1);
         @(negedge clk);
         if (i >= 3) begin
            total++;
            if (occupancy_o !== 2'd3 || wb_valid_o !== 1'b1 || in_ready_o !== 1'b1 || wb_tag_o !== TAG_W'(i - 2)) begin
               bad++;
               $display("FAIL full3 cycle=%0d got occ=%0d wbv=%b rdy=%b tag=%0d want 3 1 1 %0d",
                        i, occupancy_o, wb_valid_o, in_ready_o, wb_tag_o, i - 2);
            end
         end
         if (i >= 1) begin
            total++;
            if (occupancy1 !== 1'b1 || wb_valid1 !== 1'b1 || in_ready1 !== 1'b1 || wb_tag1 !== TAG_W'(i)) begin
               bad++;
               $display("FAIL full1 cycle=%0d got occ=%0d wbv=%b rdy=%b tag=%0d want 1 1 1 %0d",
                        i, occupancy1, wb_valid1, in_ready1, wb_tag1, i);
            end
         end
      end
      drain_idle(4);
   endtask

   initial begin
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_flush();
      test_full_shift();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
